// File: rtl/button_hex_counter.sv
// Two-button up/down counter for a two-digit hex display.
// Each raw button is synchronized and debounced, then drives a small FSM that
// emits one count event on press and auto-repeats while the button is held.
// Up and down events landing in the same cycle cancel each other.

module button_channel #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_event
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } state_t;

    logic [1:0]        sync_ff;
    logic              synced;
    logic [DB_W-1:0]   db_cnt;
    logic              db_level;
    logic              db_prev;
    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_timer;
    logic [HOLD_W-1:0] hold_next;
    logic [REP_W-1:0]  rep_timer;
    logic [REP_W-1:0]  rep_next;

    assign synced = sync_ff[1];

    // Two-flop synchronizer for the asynchronous raw button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], btn};
        end
    end

    // Debounce: level follows the input only after a full run of disagreement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (synced != db_level) begin
            if (db_cnt == DB_LAST) begin
                db_cnt   <= '0;
                db_level <= synced;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // State, timers and previous debounced level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_timer <= '0;
            rep_timer  <= '0;
            db_prev    <= 1'b0;
        end else begin
            state      <= state_next;
            hold_timer <= hold_next;
            rep_timer  <= rep_next;
            db_prev    <= db_level;
        end
    end

    // Next-state logic: press event, hold delay, then periodic repeat events
    always_comb begin
        state_next  = state;
        hold_next   = hold_timer;
        rep_next    = rep_timer;
        press_event = 1'b0;
        case (state)
            IDLE: begin
                hold_next = '0;
                rep_next  = '0;
                if (db_level && !db_prev) begin
                    state_next  = HELD;
                    press_event = 1'b1;
                end
            end
            HELD: begin
                if (!db_level) begin
                    state_next = IDLE;
                    hold_next  = '0;
                end else if (hold_timer == HOLD_LAST) begin
                    state_next  = REPEAT;
                    press_event = 1'b1;
                    hold_next   = '0;
                    rep_next    = '0;
                end else begin
                    hold_next = hold_timer + HOLD_W'(1);
                end
            end
            REPEAT: begin
                if (!db_level) begin
                    state_next = IDLE;
                    rep_next   = '0;
                end else if (rep_timer == REP_LAST) begin
                    press_event = 1'b1;
                    rep_next    = '0;
                end else begin
                    rep_next = rep_timer + REP_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                hold_next  = '0;
                rep_next   = '0;
            end
        endcase
    end

endmodule

module button_hex_counter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter int WIDTH           = 8
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic             BTNU,
    input  logic             BTND,
    output logic [WIDTH-1:0] value,
    output logic             step
);

    logic up_event;
    logic down_event;

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_up (
        .clk        (CLK100MHZ),
        .rst        (RST),
        .btn        (BTNU),
        .press_event(up_event)
    );

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_down (
        .clk        (CLK100MHZ),
        .rst        (RST),
        .btn        (BTND),
        .press_event(down_event)
    );

    // Apply a single up or down event; coincident events cancel out
    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            value <= '0;
            step  <= 1'b0;
        end else begin
            step <= up_event ^ down_event;
            if (up_event && !down_event) begin
                value <= value + WIDTH'(1);
            end else if (down_event && !up_event) begin
                value <= value - WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_button_hex_counter.sv
// Testbench for button_hex_counter: directed scenarios plus randomized button
// activity, checked by a scoreboard fed from a behavioural model.

module tb_button_hex_counter;

    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 5;

    logic       CLK100MHZ = 1'b0;
    logic       RST = 1'b1;
    logic       BTNU = 1'b0;
    logic       BTND = 1'b0;
    logic [7:0] value;
    logic       step;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t step_log[$];
    exp_t mon_e;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int step_pulses = 0;

    // model state, index 0 = up button, 1 = down button
    bit         hq0[$];
    bit         hq1[$];
    bit         y[2];
    bit         lvl[2];
    int         dis[2];
    int         high_run[2];
    bit         ev[2];
    int         k;
    logic [7:0] mvalue = 8'h00;

    button_hex_counter #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .WIDTH          (8)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .RST      (RST),
        .BTNU     (BTNU),
        .BTND     (BTND),
        .value    (value),
        .step     (step)
    );

    initial forever #5 CLK100MHZ = ~CLK100MHZ;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic u, input logic d, input int n);
        BTNU = u;
        BTND = d;
        repeat (n) @(negedge CLK100MHZ);
    endtask

    task automatic pulseReset(input int n);
        #2 RST = 1'b1;
        repeat (n) @(negedge CLK100MHZ);
        #2 RST = 1'b0;
        @(negedge CLK100MHZ);
    endtask

    // Reference model: a sample is seen by the debouncer two edges later, the
    // debounced level flips after D straight disagreements, and while a level
    // stays high events fall at k = 0, H, H+R, H+2R ... edges after the rise.
    always @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            hq0.delete();
            hq1.delete();
            exp_q.delete();
            for (int b = 0; b < 2; b++) begin
                lvl[b] = 1'b0;
                dis[b] = 0;
                high_run[b] = 0;
            end
            mvalue = 8'h00;
        end else begin
            cyc++;
            hq0.push_back(BTNU);
            hq1.push_back(BTND);
            y[0] = (hq0.size() == 3) ? hq0.pop_front() : 1'b0;
            y[1] = (hq1.size() == 3) ? hq1.pop_front() : 1'b0;
            for (int b = 0; b < 2; b++) begin
                if (lvl[b]) high_run[b]++;
                else high_run[b] = 0;
                k = high_run[b] - 1;
                ev[b] = lvl[b] && (k == 0 || k == H || (k > H && ((k - H) % R) == 0));
                if (y[b] != lvl[b]) begin
                    dis[b]++;
                    if (dis[b] == D) begin
                        lvl[b] = y[b];
                        dis[b] = 0;
                    end
                end else begin
                    dis[b] = 0;
                end
            end
            if (ev[0] != ev[1]) begin
                mvalue = ev[0] ? mvalue + 8'h01 : mvalue - 8'h01;
                exp_q.push_back('{cyc, mvalue});
            end
        end
    end

    // Monitor: pops expected updates as step pulses appear, flags stray pulses
    always @(negedge CLK100MHZ) begin
        if (RST) begin
            checkOutput("reset_value", {24'h0, value}, 32'h0);
            checkOutput("reset_step", {31'h0, step}, 32'h0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                checkOutput("missed_step", 32'h0, 32'h1);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                checkOutput("step_pulse", {31'h0, step}, 32'h1);
                checkOutput("step_value", {24'h0, value}, {24'h0, mon_e.val});
            end else begin
                checkOutput("step_idle", {31'h0, step}, 32'h0);
            end
            if (step === 1'b1) begin
                step_pulses++;
                step_log.push_back('{cyc, value});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int snap;
    int n_seg;

    initial begin
        repeat (3) @(negedge CLK100MHZ);
        checkOutput("init_value", {24'h0, value}, 32'h0);
        checkOutput("init_step", {31'h0, step}, 32'h0);
        #2 RST = 1'b0;
        @(negedge CLK100MHZ);

        // clean single press
        snap = step_pulses;
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 15);
        checkOutput("single_press_value", {24'h0, value}, 32'h01);
        checkOutput("single_press_steps", step_pulses - snap, 1);

        // bouncing input never settles long enough
        pulseReset(2);
        snap = step_pulses;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 2);
            applyStimulus(1'b0, 1'b0, 2);
        end
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("bounce_value", {24'h0, value}, 32'h00);
        checkOutput("bounce_steps", step_pulses - snap, 0);

        // held down button: press, hold delay, then repeats
        pulseReset(2);
        step_log.delete();
        applyStimulus(1'b0, 1'b1, 46);
        applyStimulus(1'b0, 1'b0, 15);
        checkOutput("hold_log_size", step_log.size(), 7);
        if (step_log.size() >= 3) begin
            checkOutput("hold_first", {24'h0, step_log[0].val}, 32'hFF);
            checkOutput("hold_second", {24'h0, step_log[1].val}, 32'hFE);
            checkOutput("hold_gap", step_log[1].cyc - step_log[0].cyc, H);
            checkOutput("hold_third", {24'h0, step_log[2].val}, 32'hFD);
            checkOutput("repeat_gap", step_log[2].cyc - step_log[1].cyc, R);
        end
        checkOutput("hold_final", {24'h0, value}, 32'hF9);

        // wrap in both directions
        pulseReset(2);
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 15);
        checkOutput("wrap_down", {24'h0, value}, 32'hFF);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 15);
        checkOutput("wrap_up", {24'h0, value}, 32'h00);

        // both buttons together cancel; up keeps repeating after down release
        pulseReset(2);
        snap = step_pulses;
        applyStimulus(1'b1, 1'b1, 30);
        checkOutput("both_steps", step_pulses - snap, 0);
        checkOutput("both_value", {24'h0, value}, 32'h00);
        applyStimulus(1'b1, 1'b0, 30);
        applyStimulus(1'b0, 1'b0, 15);
        checkOutput("up_after_both", {24'h0, value}, 32'h06);

        // asynchronous reset during repeat, button still held afterwards
        pulseReset(2);
        applyStimulus(1'b1, 1'b0, 35);
        checkOutput("pre_reset_value", {24'h0, value}, 32'h03);
        #2 RST = 1'b1;
        #1;
        checkOutput("async_reset_value", {24'h0, value}, 32'h0);
        checkOutput("async_reset_step", {31'h0, step}, 32'h0);
        repeat (3) @(negedge CLK100MHZ);
        #2 RST = 1'b0;
        @(negedge CLK100MHZ);
        snap = step_pulses;
        applyStimulus(1'b1, 1'b0, 12);
        checkOutput("post_reset_steps", step_pulses - snap, 1);
        checkOutput("post_reset_value", {24'h0, value}, 32'h01);
        applyStimulus(1'b0, 1'b0, 15);

        // randomized button activity with occasional asynchronous resets
        n_seg = 60;
        for (int s = 0; s < n_seg; s++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(1, 40));
            if ($urandom_range(0, 11) == 0) pulseReset($urandom_range(1, 3));
        end

        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("final_value", {24'h0, value}, {24'h0, mvalue});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_hex_counter.md
BUTTON_HEX_COUNTER -- requirements
Module: button_hex_counter

Interface
REQ-001 Parameters SHALL be: DEBOUNCE_CYCLES, default 1_000_000, input-stable time (10 ms at 100 MHz); HOLD_CYCLES, default 50_000_000, hold time before auto-repeat starts (500 ms); REPEAT_CYCLES, default 10_000_000, auto-repeat period (100 ms); WIDTH, default 8, count width.
REQ-002 CLK100MHZ  input  1  system clock, 100 MHz; the only clock in the block.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 BTNU  input  1  increment push-button, raw, asynchronous to the clock, active-high.
REQ-005 BTND  input  1  decrement push-button, raw, asynchronous to the clock, active-high.
REQ-006 value  output  WIDTH  current count; feeds the two-digit hex display stage (value[7:4] is the leading digit, value[3:0] the last digit).
REQ-007 step  output  1  one-cycle pulse, high in the cycle after value changes.

Function
REQ-008 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-009 Debounce per button: a counter SHALL reset whenever the synchronized input differs from the debounced level; the debounced level SHALL take the synchronized value only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
REQ-010 Per-button FSM states: IDLE, HELD, REPEAT.
REQ-011 IDLE -> HELD on a debounced rising edge; this SHALL issue one count event in the same cycle and clear the hold timer.
REQ-012 HELD -> REPEAT when the hold timer reaches HOLD_CYCLES-1 with the button still debounced-high; this SHALL issue one event and clear the repeat timer.
REQ-013 In REPEAT, an event SHALL be issued each time the repeat timer reaches REPEAT_CYCLES-1, after which the timer clears.
REQ-014 HELD or REPEAT -> IDLE when the debounced level goes low; no event SHALL be issued on release.
REQ-015 An up event SHALL give value <= value+1 and a down event value <= value-1, both modulo 2^WIDTH (0xFF+1 = 0x00, 0x00-1 = 0xFF).
REQ-016 Up and down events in the same cycle SHALL leave value unchanged and SHALL NOT assert step.
REQ-017 If both buttons are held, each FSM SHALL run independently; only coincident events cancel.
REQ-018 Latency SHALL be fixed: value updates on the clock edge after the event cycle, and step is high for exactly that one following cycle.
REQ-019 Timer widths SHALL be sized from the parameters (clog2). Parameter values below 1 are unsupported.

Reset
REQ-020 While RST is high, all of the following SHALL be forced asynchronously and held: value = 0, step = 0, synchronizers = 0, debounced levels = 0, all timers = 0, both FSMs in IDLE.
REQ-021 Reset deassertion mid-press SHALL be handled as follows: a button already high SHALL be debounced afresh and then produce one event (a normal rising edge from the reset level of 0).
REQ-022 Reset asserted mid-operation (during HELD or REPEAT) SHALL abandon all pending timers with no event issued.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5)
REQ-023 Apply RST, then press BTNU clean for 10 cycles and release: value = 0x01 and step is asserted exactly once.
REQ-024 Toggle BTNU every 2 cycles for 30 cycles, then leave it low: value is unchanged at 0x00 and step is never asserted.
REQ-025 Hold BTND from value 0x00 for 40 cycles after debounce: the first event gives 0xFF, the repeat after 20 cycles gives 0xFE, and each later event follows 5 cycles apart (0xFD, ...).
REQ-026 With value 0xFF, press BTNU: value = 0x00 (wrap).
REQ-027 Press BTNU and BTND with identical timing: value does not change and step stays 0; release BTND while BTNU is held, and the BTNU repeats then increment value.
REQ-028 Assert RST asynchronously (between clock edges) during REPEAT: value and step go to 0 immediately; after release with BTNU still held, exactly one event occurs after DEBOUNCE_CYCLES plus the synchronizer delay.
